// File: rtl/ysyx_2022040010_lsu.sv
// Load/store stage: ALU pass-through plus one outstanding data-memory access; optional LSU_MISALIGN_CHK_EN.
// Latency: non-memory write-back 1 cycle after accept, loads 3 cycles minimum (plus memory stall/response delay).
// Backpressure: ex_ready low while a request is pending or awaiting its response; request held until mem_req_ready.
module ysyx_2022040010_lsu #(
  parameter int XLEN = 64,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_rd_we,
  input  logic [RAW-1:0]  ex_rd_addr,
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] ex_sdata,
  input  logic [3:0]      ex_mem_op,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_we,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [XLEN-1:0] mem_req_wdata,
  output logic [7:0]      mem_req_wmask,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_rdata,
  output logic            wb_we,
  output logic [RAW-1:0]  wb_waddr,
  output logic [XLEN-1:0] wb_wdata,
  output logic            mem_misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [2:0]      off_q, off_d;
  logic            rd_we_q, rd_we_d;
  logic [RAW-1:0]  rd_q, rd_d;
  logic            req_valid_q, req_valid_d;
  logic            req_we_q, req_we_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] req_wdata_q, req_wdata_d;
  logic [7:0]      req_wmask_q, req_wmask_d;
  logic            wb_we_q, wb_we_d;
  logic [RAW-1:0]  wb_waddr_q, wb_waddr_d;
  logic [XLEN-1:0] wb_wdata_q, wb_wdata_d;
`ifdef LSU_MISALIGN_CHK_EN
  logic            misalign_q, misalign_d;
  logic            ex_misaligned;
`endif

  logic            ex_is_mem, ex_is_store;
  logic [7:0]      size_mask;
  logic [2:0]      low_mask;
  logic [2:0]      ex_off;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] ld_data;

  // Access size decode: byte-enable pattern and the address bits that must be zero.
  always_comb begin
    ex_is_mem   = (ex_mem_op >= 4'd1) && (ex_mem_op <= 4'd11);
    ex_is_store = (ex_mem_op >= 4'd8) && (ex_mem_op <= 4'd11);
    case (ex_mem_op)
      4'd1, 4'd5, 4'd8:  begin size_mask = 8'h01; low_mask = 3'b000; end
      4'd2, 4'd6, 4'd9:  begin size_mask = 8'h03; low_mask = 3'b001; end
      4'd3, 4'd7, 4'd10: begin size_mask = 8'h0F; low_mask = 3'b011; end
      default:           begin size_mask = 8'hFF; low_mask = 3'b111; end
    endcase
    ex_off = ex_result[2:0] & ~low_mask;
  end

`ifdef LSU_MISALIGN_CHK_EN
  assign ex_misaligned = |(ex_result[2:0] & low_mask);
`endif

  assign lane = mem_rsp_rdata >> {off_q, 3'b000};

  always_comb begin
    case (op_q)
      4'd1:    ld_data = {{(XLEN-8){lane[7]}},   lane[7:0]};
      4'd2:    ld_data = {{(XLEN-16){lane[15]}}, lane[15:0]};
      4'd3:    ld_data = {{(XLEN-32){lane[31]}}, lane[31:0]};
      4'd5:    ld_data = {{(XLEN-8){1'b0}},      lane[7:0]};
      4'd6:    ld_data = {{(XLEN-16){1'b0}},     lane[15:0]};
      4'd7:    ld_data = {{(XLEN-32){1'b0}},     lane[31:0]};
      default: ld_data = lane;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    off_d       = off_q;
    rd_we_d     = rd_we_q;
    rd_d        = rd_q;
    req_valid_d = req_valid_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wmask_d = req_wmask_q;
    wb_we_d     = 1'b0;
    wb_waddr_d  = wb_waddr_q;
    wb_wdata_d  = wb_wdata_q;
`ifdef LSU_MISALIGN_CHK_EN
    misalign_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (!ex_is_mem) begin
            wb_we_d    = ex_rd_we && (ex_rd_addr != '0);
            wb_waddr_d = ex_rd_addr;
            wb_wdata_d = ex_result;
          end
`ifdef LSU_MISALIGN_CHK_EN
          else if (ex_misaligned) begin
            misalign_d = 1'b1;
          end
`endif
          else begin
            op_d        = ex_mem_op;
            off_d       = ex_off;
            rd_we_d     = ex_rd_we;
            rd_d        = ex_rd_addr;
            req_valid_d = 1'b1;
            req_we_d    = ex_is_store;
            req_addr_d  = {ex_result[XLEN-1:3], 3'b000};
            req_wdata_d = ex_is_store ? (ex_sdata << {ex_off, 3'b000}) : '0;
            req_wmask_d = ex_is_store ? (size_mask << ex_off) : 8'h00;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          state_d = IDLE;
          if (!op_q[3]) begin
            wb_we_d    = rd_we_q && (rd_q != '0);
            wb_waddr_d = rd_q;
            wb_wdata_d = ld_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      off_q       <= '0;
      rd_we_q     <= 1'b0;
      rd_q        <= '0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wmask_q <= '0;
      wb_we_q     <= 1'b0;
      wb_waddr_q  <= '0;
      wb_wdata_q  <= '0;
`ifdef LSU_MISALIGN_CHK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      off_q       <= off_d;
      rd_we_q     <= rd_we_d;
      rd_q        <= rd_d;
      req_valid_q <= req_valid_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wmask_q <= req_wmask_d;
      wb_we_q     <= wb_we_d;
      wb_waddr_q  <= wb_waddr_d;
      wb_wdata_q  <= wb_wdata_d;
`ifdef LSU_MISALIGN_CHK_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  assign ex_ready      = (state_q == IDLE);
  assign mem_req_valid = req_valid_q;
  assign mem_req_we    = req_we_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_wmask = req_wmask_q;
  assign wb_we         = wb_we_q;
  assign wb_waddr      = wb_waddr_q;
  assign wb_wdata      = wb_wdata_q;
`ifdef LSU_MISALIGN_CHK_EN
  assign mem_misalign  = misalign_q;
`else
  assign mem_misalign  = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_2022040010_lsu.sv
// Scoreboard bench for ysyx_2022040010_lsu: directed cases then random traffic against a byte-level model.
module tb_ysyx_2022040010_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0, ex_rd_we = 1'b0;
  logic [4:0]  ex_rd_addr = '0;
  logic [63:0] ex_result = '0, ex_sdata = '0;
  logic [3:0]  ex_mem_op = '0;
  logic        mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
  logic [63:0] mem_rsp_rdata = '0;
  logic        ex_ready, mem_req_valid, mem_req_we, wb_we, mem_misalign;
  logic [63:0] mem_req_addr, mem_req_wdata, wb_wdata;
  logic [7:0]  mem_req_wmask;
  logic [4:0]  wb_waddr;

  ysyx_2022040010_lsu dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd_we(ex_rd_we), .ex_rd_addr(ex_rd_addr),
    .ex_result(ex_result), .ex_sdata(ex_sdata), .ex_mem_op(ex_mem_op),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .mem_misalign(mem_misalign)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  op;
    logic        rd_we;
    logic [4:0]  rd;
    logic [63:0] res, sdata, rdata;
    int          stall, dly;
  } ins_t;
  typedef struct { logic [4:0] a; logic [63:0] d; int c; } wb_t;
  typedef struct { logic [63:0] addr, wdata; logic we; logic [7:0] m; } req_t;

  wb_t  wb_q[$];
  req_t req_q[$];
  int   mis_q[$];

  int n_vec = 0, n_err = 0;
  bit mon_en = 0;

  bit   busy = 0, first = 0;
  int   rphase = 0, stall_left = 0, dly_left = 0, cur_off = 0, acc_cyc = 0;
  ins_t cur;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit is_mem(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd11);
  endfunction

  function automatic int nbytes(input logic [3:0] op);
    case (op)
      4'd1, 4'd5, 4'd8:  return 1;
      4'd2, 4'd6, 4'd9:  return 2;
      4'd3, 4'd7, 4'd10: return 4;
      default:           return 8;
    endcase
  endfunction

  // Gather n bytes starting at byte offset, then extend according to the opcode.
  function automatic logic [63:0] load_val(input logic [63:0] rd, input int off, input logic [3:0] op);
    int n;
    logic [63:0] v;
    n = nbytes(op);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
    if (op >= 4'd1 && op <= 4'd3)
      for (int k = 8*n; k < 64; k++) v[k] = v[8*n-1];
    return v;
  endfunction

  function automatic ins_t mk(input logic [3:0] op, input logic we, input logic [4:0] rd,
                              input logic [63:0] res, input logic [63:0] sd, input logic [63:0] rdat,
                              input int stall, input int dly);
    ins_t x;
    x.op = op; x.rd_we = we; x.rd = rd; x.res = res; x.sdata = sd; x.rdata = rdat;
    x.stall = stall; x.dly = dly;
    return x;
  endfunction

  task automatic accept(input ins_t x);
    int n, o;
    logic [63:0] wd;
    logic [7:0]  m;
    req_t r;
    if (!is_mem(x.op)) begin
      if (x.rd_we && x.rd != 5'd0) wb_q.push_back('{x.rd, x.res, cyc + 1});
      return;
    end
    n = nbytes(x.op);
`ifdef LSU_MISALIGN_CHK_EN
    if (int'(x.res[2:0]) % n != 0) begin
      mis_q.push_back(cyc + 1);
      return;
    end
    o = int'(x.res[2:0]);
`else
    o = int'(x.res[2:0]) / n * n;
`endif
    wd = '0;
    m  = '0;
    for (int b = 0; b < 8; b++) if (b >= o) wd[8*b +: 8] = x.sdata[8*(b-o) +: 8];
    for (int i = 0; i < n; i++) m[o+i] = 1'b1;
    r.addr = {x.res[63:3], 3'b000}; r.wdata = wd; r.we = (x.op >= 4'd8); r.m = m;
    req_q.push_back(r);
    cur = x; cur_off = o; busy = 1; rphase = 1; first = 1; acc_cyc = cyc;
    stall_left = x.stall; dly_left = x.dly;
  endtask

  // One clock of stimulus: memory responder first, then the execute-side offer.
  task automatic cycle(input bit offer, input ins_t x, output bit taken);
    bit rdy;
    @(posedge clk);
    #1;
    rdy = !busy;
    chk("ex_ready", 64'(ex_ready), 64'(rdy));
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = {$urandom, $urandom};
    case (rphase)
      1: begin
        if (first) begin
          chk("req_valid_at_t1", 64'(mem_req_valid), 64'd1);
          first = 0;
        end
        mem_rsp_valid = 1'($urandom_range(1));
        if (stall_left > 0) stall_left--;
        else begin
          mem_req_ready = 1'b1;
          rphase = 2;
        end
      end
      2: begin
        if (dly_left > 0) dly_left--;
        else begin
          chk("req_dropped_in_wait", 64'(mem_req_valid), 64'd0);
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = cur.rdata;
          rphase = 0;
          busy = 0;
          if (cur.op < 4'd8 && cur.rd_we && cur.rd != 5'd0)
            wb_q.push_back('{cur.rd, load_val(cur.rdata, cur_off, cur.op), cyc + 1});
        end
      end
      default: mem_rsp_valid = ($urandom_range(3) == 0);
    endcase
    ex_valid = offer;
    if (offer) begin
      ex_mem_op = x.op; ex_rd_we = x.rd_we; ex_rd_addr = x.rd; ex_result = x.res; ex_sdata = x.sdata;
    end else begin
      ex_mem_op = 4'($urandom); ex_rd_we = 1'($urandom); ex_rd_addr = 5'($urandom);
      ex_result = {$urandom, $urandom}; ex_sdata = {$urandom, $urandom};
    end
    taken = offer && rdy;
    if (taken) accept(x);
  endtask

  task automatic issue(input ins_t x);
    bit t;
    int g;
    t = 0;
    g = 0;
    while (!t && g < 50) begin
      cycle(1'b1, x, t);
      g++;
    end
    if (!t) chk("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    bit t;
    cycle(1'b0, mk(4'd0, 1'b0, 5'd0, 64'd0, 64'd0, 64'd0, 0, 0), t);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 100) begin
      idle();
      g++;
    end
    if (busy) chk("drain_timeout", 64'd0, 64'd1);
    idle();
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  wb_t  mw;
  req_t mr;
  always @(negedge clk) begin
    if (mon_en) begin
      if (wb_we) begin
        if (wb_q.size() == 0) chk("wb_unexpected", 64'd1, 64'd0);
        else begin
          mw = wb_q.pop_front();
          chk("wb_waddr", 64'(wb_waddr), 64'(mw.a));
          chk("wb_wdata", wb_wdata, mw.d);
          chk("wb_cycle", 64'(cyc), 64'(mw.c));
        end
      end else if (wb_q.size() != 0 && wb_q[0].c <= cyc) begin
        void'(wb_q.pop_front());
        chk("wb_missing", 64'd0, 64'd1);
      end
      if (mem_req_valid) begin
        if (req_q.size() == 0) chk("req_unexpected", 64'd1, 64'd0);
        else begin
          mr = req_q[0];
          chk("req_addr", mem_req_addr, mr.addr);
          chk("req_we", 64'(mem_req_we), 64'(mr.we));
          if (mr.we) begin
            chk("req_wdata", mem_req_wdata, mr.wdata);
            chk("req_wmask", 64'(mem_req_wmask), 64'(mr.m));
          end
          if (mem_req_ready) void'(req_q.pop_front());
        end
      end
      if (mem_misalign) begin
        if (mis_q.size() == 0) chk("misalign_unexpected", 64'd1, 64'd0);
        else chk("misalign_cycle", 64'(cyc), 64'(mis_q.pop_front()));
      end else if (mis_q.size() != 0 && mis_q[0] <= cyc) begin
        void'(mis_q.pop_front());
        chk("misalign_missing", 64'd0, 64'd1);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, expected finish within budget");
    $fatal(1);
  end

  initial begin
    ins_t x;
    // Reset held with a live instruction offered; nothing may come out of it.
    rst = 1'b0; ex_valid = 1'b1; ex_mem_op = 4'd0; ex_rd_we = 1'b1; ex_rd_addr = 5'd5;
    ex_result = 64'h1234;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_we", 64'(wb_we), 64'd0);
    chk("rst_wb_waddr", 64'(wb_waddr), 64'd0);
    chk("rst_wb_wdata", wb_wdata, 64'd0);
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_req_we", 64'(mem_req_we), 64'd0);
    chk("rst_req_addr", mem_req_addr, 64'd0);
    chk("rst_req_wdata", mem_req_wdata, 64'd0);
    chk("rst_req_wmask", 64'(mem_req_wmask), 64'd0);
    chk("rst_misalign", 64'(mem_misalign), 64'd0);
    rst = 1'b1; ex_valid = 1'b0; mon_en = 1;

    x = mk(4'd0, 1'b1, 5'd5, 64'h1234, 64'd0, 64'd0, 0, 0);
    repeat (3) issue(x);
    x.rd = 5'd0; issue(x);
    x.rd = 5'd6; x.rd_we = 1'b0; issue(x);
    idle();

    issue(mk(4'd1, 1'b1, 5'd10, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0));
    wait_idle();
    issue(mk(4'd5, 1'b1, 5'd11, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0));
    wait_idle();
    issue(mk(4'd9, 1'b1, 5'd3, 64'h2006, 64'hBEEF, 64'd0, 4, 1));
    wait_idle();

    // Reset while the load waits for its response; the late response must be ignored.
    issue(mk(4'd4, 1'b1, 5'd7, 64'h4000, 64'd0, 64'hDEAD_BEEF_0123_4567, 0, 3));
    idle();
    idle();
    rst = 1'b0; busy = 0; rphase = 0;
    idle();
    rst = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'hDEAD_BEEF_0123_4567;
    repeat (3) idle();
    issue(mk(4'd0, 1'b1, 5'd12, 64'h55AA, 64'd0, 64'd0, 0, 0));
    idle();

    issue(mk(4'd3, 1'b1, 5'd9, 64'h3002, 64'd0, 64'h1111_2222_8765_4321, 0, 0));
    wait_idle();

    for (int i = 0; i < 400; i++) begin
      x = mk(4'($urandom_range(15)), ($urandom_range(3) != 0), 5'($urandom),
             {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             int'($urandom_range(3)), int'($urandom_range(3)));
      if ($urandom_range(3) == 0) idle();
      issue(x);
    end
    wait_idle();
    repeat (3) idle();
    chk("wb_queue_drained", 64'(wb_q.size()), 64'd0);
    chk("req_queue_drained", 64'(req_q.size()), 64'd0);
    chk("misalign_queue_drained", 64'(mis_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
